// File: rtl/motor_arm_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// motor_arm_sequencer
//
// Gates receiver throttle onto the motor rate path feeding pwm_generator.
// Enforces the ESC arm sequence: the arm switch must be on and the throttle
// must stay low for ARM_HOLD_US cycles before the motor output is released.
// The block also handles disarm, and it enters failsafe when receiver frames
// stop arriving. motor_1_rate is 0 in every state except ARMED.
//
// Optional feature macro: MOTOR_SLEW_LIMIT_EN
//   Defined     : in ARMED the rate approaches thr_q by at most SLEW_STEP
//                 once every SLEW_PERIOD_US cycles (parameters exist only here).
//   Not defined : in ARMED the rate tracks thr_q directly.
//
// Ports
//   us_clk         in   1  1 MHz clock, all logic on posedge
//   resetn         in   1  asynchronous active-low reset
//   throttle_val   in   8  receiver throttle, sampled when throttle_valid=1
//   throttle_valid in   1  one-cycle pulse per completed receiver frame
//   arm_req        in   1  arm switch (asynchronous, 2-flop synchronised)
//   motor_1_rate   out  8  gated rate to pwm_generator
//   armed          out  1  state == ARMED
//   failsafe       out  1  state == FAILSAFE
//   seq_state      out  2  00 DISARMED, 01 ARMING, 10 ARMED, 11 FAILSAFE
// -----------------------------------------------------------------------------
module motor_arm_sequencer #(
  parameter logic [7:0]  THR_LOW_MAX      = 8'd10,
  parameter int unsigned ARM_HOLD_US      = 2_000_000,
  parameter int unsigned FRAME_TIMEOUT_US = 100_000
`ifdef MOTOR_SLEW_LIMIT_EN
  ,
  parameter logic [7:0]  SLEW_STEP        = 8'd4,
  parameter int unsigned SLEW_PERIOD_US   = 1000
`endif
) (
  input  logic       us_clk,
  input  logic       resetn,
  input  logic [7:0] throttle_val,
  input  logic       throttle_valid,
  input  logic       arm_req,
  output logic [7:0] motor_1_rate,
  output logic       armed,
  output logic       failsafe,
  output logic [1:0] seq_state
);

  localparam int FRAME_W = $clog2(FRAME_TIMEOUT_US + 1);
  localparam int HOLD_W  = $clog2(ARM_HOLD_US + 1);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'b00,
    ST_ARMING   = 2'b01,
    ST_ARMED    = 2'b10,
    ST_FAILSAFE = 2'b11
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_arm_s1;
  logic               r_arm_s2;
  logic [7:0]         r_thr_q;
  logic               r_seen_frame;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [7:0]         r_rate;
  logic [7:0]         w_rate_nxt;
  logic               r_armed;
  logic               r_failsafe;
  logic               w_timeout;
  logic               w_thr_low;
  logic               w_hold_done;

`ifdef MOTOR_SLEW_LIMIT_EN
  localparam int SLEW_W = $clog2(SLEW_PERIOD_US + 1);

  logic [SLEW_W-1:0]  r_slew_cnt;
  logic [SLEW_W-1:0]  w_slew_nxt;

  // One slew step toward the target. The difference is formed in 9-bit
  // signed arithmetic, so neither direction can wrap the 8-bit rate.
  function automatic logic [7:0] f_slew_step(input logic [7:0] cur,
                                             input logic [7:0] tgt);
    logic signed [8:0] diff;
    logic signed [8:0] step;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    step = $signed({1'b0, SLEW_STEP});
    if (diff > step) begin
      f_slew_step = cur + SLEW_STEP;
    end else if (diff < -step) begin
      f_slew_step = cur - SLEW_STEP;
    end else begin
      f_slew_step = tgt;
    end
  endfunction
`endif

  // A frame arriving on the saturation cycle suppresses the timeout.
  assign w_timeout   = (r_frame_cnt == FRAME_W'(FRAME_TIMEOUT_US)) && !throttle_valid;
  assign w_thr_low   = (r_thr_q <= THR_LOW_MAX);
  assign w_hold_done = (r_hold_cnt == HOLD_W'(ARM_HOLD_US - 1));

  // Input capture: arm switch synchroniser, throttle hold, and frame watchdog.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      r_arm_s1     <= 1'b0;
      r_arm_s2     <= 1'b0;
      r_thr_q      <= 8'd0;
      r_seen_frame <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_arm_s1 <= arm_req;
      r_arm_s2 <= r_arm_s1;
      if (throttle_valid) begin
        r_thr_q      <= throttle_val;
        r_seen_frame <= 1'b1;
        r_frame_cnt  <= '0;
      end else if (r_frame_cnt != FRAME_W'(FRAME_TIMEOUT_US)) begin
        r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
      end
    end
  end

  // State register
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_DISARMED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state. Priority: timeout, then switch off, then the per-state rule.
  // DISARMED ignores the timeout apart from refusing to start arming.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_DISARMED: begin
        if (r_arm_s2 && r_seen_frame && w_thr_low && !w_timeout) begin
          w_state_nxt = ST_ARMING;
        end
      end
      ST_ARMING: begin
        if (w_timeout) begin
          w_state_nxt = ST_FAILSAFE;
        end else if (!r_arm_s2 || !w_thr_low) begin
          w_state_nxt = ST_DISARMED;
        end else if (w_hold_done) begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (w_timeout) begin
          w_state_nxt = ST_FAILSAFE;
        end else if (!r_arm_s2) begin
          w_state_nxt = ST_DISARMED;
        end
      end
      ST_FAILSAFE: begin
        // Resumed frames do not clear failsafe; only switching off does.
        if (!w_timeout && !r_arm_s2) begin
          w_state_nxt = ST_DISARMED;
        end
      end
      default: w_state_nxt = ST_DISARMED;
    endcase
  end

  // Hold counter: zero on the ARMING entry edge, then +1 per ARMING cycle,
  // so ARMED appears exactly ARM_HOLD_US cycles after ARMING appears.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      r_hold_cnt <= '0;
    end else if (r_state == ST_ARMING) begin
      r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
    end else begin
      r_hold_cnt <= '0;
    end
  end

  // Rate is derived from the next state, so leaving ARMED zeroes the rate
  // on the same edge that the state changes.
  always_comb begin
    w_rate_nxt = 8'd0;
`ifdef MOTOR_SLEW_LIMIT_EN
    w_slew_nxt = '0;
    if (w_state_nxt == ST_ARMED && r_state == ST_ARMED) begin
      if (r_slew_cnt == SLEW_W'(SLEW_PERIOD_US - 1)) begin
        w_rate_nxt = f_slew_step(r_rate, r_thr_q);
      end else begin
        w_rate_nxt = r_rate;
        w_slew_nxt = r_slew_cnt + SLEW_W'(1);
      end
    end
`else
    if (w_state_nxt == ST_ARMED) begin
      w_rate_nxt = r_thr_q;
    end
`endif
  end

  // Registered outputs
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      r_rate     <= 8'd0;
      r_armed    <= 1'b0;
      r_failsafe <= 1'b0;
    end else begin
      r_rate     <= w_rate_nxt;
      r_armed    <= (w_state_nxt == ST_ARMED);
      r_failsafe <= (w_state_nxt == ST_FAILSAFE);
    end
  end

`ifdef MOTOR_SLEW_LIMIT_EN
  // Slew timer free-runs while ARMED and is cleared in all other states.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      r_slew_cnt <= '0;
    end else begin
      r_slew_cnt <= w_slew_nxt;
    end
  end
`endif

  assign motor_1_rate = r_rate;
  assign armed        = r_armed;
  assign failsafe     = r_failsafe;
  assign seq_state    = r_state;

endmodule
